// File: rtl/mxn_elastic_pipeline_if.sv
// Valid/ready bus for mxn_elastic_pipeline: write side (in*) and read side (out*).
// Handshake: a word moves on a side exactly when valid & ready are both 1 at posedge clk.
interface mxn_elastic_pipeline_if #(
  parameter int M = 3
);
  logic [M-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] out;
  logic         out_valid;
  logic         out_ready;

  // master: producer + reader side; slave: the pipeline itself
  modport master (output in, in_valid, out_ready, input in_ready, out, out_valid);
  modport slave  (input in, in_valid, out_ready, output in_ready, out, out_valid);
endinterface

// File: rtl/mxn_elastic_pipeline.sv
// M-bit, N-stage elastic pipeline with backpressure and bubble compression.
// Optional synchronous flush input enabled by defining PIPE_FLUSH_EN.
module mxn_elastic_pipeline #(
  parameter int M  = 3,
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef PIPE_FLUSH_EN
  input  logic                 flush,
`endif
  mxn_elastic_pipeline_if.slave bus,
  output logic [CW-1:0]        occupancy
);

  // Index 0 is stage 1 (input end), index N-1 is stage N (drives out).
  logic [M-1:0] d [N];
  logic [N-1:0] v;
  logic [N-1:0] adv;
  logic [N-1:0] free;
  logic         accept;
  logic         flush_i;

`ifdef PIPE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Advance chain from the output end back to the input end; an empty
  // stage is always free, which is what squeezes bubbles out under stall.
  always_comb begin
    adv = '0;
    free = '0;
    adv[N-1]  = v[N-1] & bus.out_ready;
    free[N-1] = ~v[N-1] | adv[N-1];
    for (int k = N - 2; k >= 0; k--) begin
      adv[k]  = v[k] & free[k+1];
      free[k] = ~v[k] | adv[k];
    end
  end

  assign bus.in_ready  = free[0] & ~flush_i;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out       = d[N-1];
  assign bus.out_valid = v[N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v         <= '0;
      occupancy <= '0;
      for (int k = 0; k < N; k++) d[k] <= '0;
    end else if (flush_i) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      if (accept) begin
        d[0] <= bus.in;
        v[0] <= 1'b1;
      end else if (adv[0]) begin
        v[0] <= 1'b0;
      end
      for (int k = 1; k < N; k++) begin
        if (adv[k-1]) begin
          d[k] <= d[k-1];
          v[k] <= 1'b1;
        end else if (adv[k]) begin
          v[k] <= 1'b0;
        end
      end
      occupancy <= occupancy + CW'(accept) - CW'(adv[N-1]);
    end
  end

endmodule

// File: tb/tb_mxn_elastic_pipeline.sv
// Bench for mxn_elastic_pipeline: directed vector table, flush sequence
// (when PIPE_FLUSH_EN is defined) and random traffic against a queue model.
module tb_mxn_elastic_pipeline;
  localparam int M  = 3;
  localparam int N  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [CW-1:0] occupancy;

  mxn_elastic_pipeline_if #(.M(M)) bus_if ();

  mxn_elastic_pipeline #(.M(M), .N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .bus       (bus_if.slave),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO of accepted words plus the number of edges each
  // has spent inside. The head word is visible once it has aged N-1 edges.
  logic [M-1:0] exp_q[$];
  int           age_q[$];

  typedef struct {
    logic         r;
    logic [M-1:0] din;
    logic         iv;
    logic         ordy;
    logic         exp_ir;
    logic         exp_ov;
    logic [M-1:0] exp_out;
    logic [CW-1:0] exp_occ;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_ov();
    return (exp_q.size() > 0) && (age_q[0] >= N - 1);
  endfunction

  function automatic logic model_ir(input logic ordy, input logic fl);
    return !((exp_q.size() == N) && !ordy) && !fl;
  endfunction

  // One clock: drive at negedge, sample in_ready before the edge, advance
  // the model at the edge, then check the registered outputs.
  task automatic apply(input logic r, input logic [M-1:0] din, input logic iv,
                       input logic ordy, input logic fl, output logic got_ir);
    logic ov_m, ir_m, acc;
    @(negedge clk);
    rst_n = r;
    bus_if.in = din;
    bus_if.in_valid = iv;
    bus_if.out_ready = ordy;
    flush = fl;
    #1;
    got_ir = bus_if.in_ready;
    ov_m = model_ov();
    ir_m = model_ir(ordy, fl);
    if (r) chk("model_in_ready", {31'b0, got_ir}, {31'b0, ir_m});
    @(posedge clk);
    if (!r || fl) begin
      exp_q.delete();
      age_q.delete();
    end else begin
      acc = iv && ir_m;
      if (ov_m && ordy) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      for (int i = 0; i < age_q.size(); i++) age_q[i]++;
      if (acc) begin
        exp_q.push_back(din);
        age_q.push_back(0);
      end
    end
    #1;
    chk("model_out_valid", {31'b0, bus_if.out_valid}, {31'b0, model_ov()});
    chk("model_occupancy", {29'b0, occupancy}, exp_q.size());
    if (model_ov()) chk("model_out", {29'b0, bus_if.out}, {29'b0, exp_q[0]});
  endtask

  initial begin
    logic got_ir;
    logic fl;
    rst_n = 1'b0;
    flush = 1'b0;
    bus_if.in = '0;
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b0;

    // {rst_n, in, in_valid, out_ready | in_ready, out_valid, out, occupancy}
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 0});
    // stream 1..6 with reader always ready, then drain
    tbl.push_back('{1, 1, 1, 1, 1, 0, 0, 1});
    tbl.push_back('{1, 2, 1, 1, 1, 0, 0, 2});
    tbl.push_back('{1, 3, 1, 1, 1, 0, 0, 3});
    tbl.push_back('{1, 4, 1, 1, 1, 1, 1, 4});
    tbl.push_back('{1, 5, 1, 1, 1, 1, 2, 4});
    tbl.push_back('{1, 6, 1, 1, 1, 1, 3, 4});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 4, 3});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 5, 2});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 6, 1});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0});
    // fill under stall; fifth push refused
    tbl.push_back('{1, 7, 1, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 6, 1, 0, 1, 0, 0, 2});
    tbl.push_back('{1, 5, 1, 0, 1, 0, 0, 3});
    tbl.push_back('{1, 4, 1, 0, 1, 1, 7, 4});
    tbl.push_back('{1, 3, 1, 0, 0, 1, 7, 4});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 7, 4});
    // simultaneous read/write when full, then drain
    tbl.push_back('{1, 2, 1, 1, 1, 1, 6, 4});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 5, 3});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 4, 2});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 2, 1});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0});
    // bubble compression under stall, then back-to-back release
    tbl.push_back('{1, 1, 1, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 2, 1, 0, 1, 1, 1, 2});
    tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 2});
    tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 2});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 2, 1});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0});
    // reset with three words in flight; nothing may emerge afterwards
    tbl.push_back('{1, 1, 1, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 2, 1, 0, 1, 0, 0, 2});
    tbl.push_back('{1, 3, 1, 0, 1, 0, 0, 3});
    tbl.push_back('{0, 4, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0});

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].din, tbl[i].iv, tbl[i].ordy, 1'b0, got_ir);
      if (tbl[i].r) chk($sformatf("vec%0d_in_ready", i), {31'b0, got_ir}, {31'b0, tbl[i].exp_ir});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, bus_if.out_valid}, {31'b0, tbl[i].exp_ov});
      chk($sformatf("vec%0d_occupancy", i), {29'b0, occupancy}, {29'b0, tbl[i].exp_occ});
      if (tbl[i].exp_ov) chk($sformatf("vec%0d_out", i), {29'b0, bus_if.out}, {29'b0, tbl[i].exp_out});
    end

`ifdef PIPE_FLUSH_EN
    for (int k = 1; k <= 4; k++) apply(1'b1, 3'(k), 1'b1, 1'b0, 1'b0, got_ir);
    chk("flush_pre_occupancy", {29'b0, occupancy}, 4);
    apply(1'b1, 3'd5, 1'b1, 1'b1, 1'b1, got_ir);
    chk("flush_in_ready", {31'b0, got_ir}, 0);
    chk("flush_occupancy", {29'b0, occupancy}, 0);
    chk("flush_out_valid", {31'b0, bus_if.out_valid}, 0);
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, got_ir);
      chk("flush_after_out_valid", {31'b0, bus_if.out_valid}, 0);
    end
`endif

    for (int i = 0; i < 400; i++) begin
`ifdef PIPE_FLUSH_EN
      fl = ($urandom_range(0, 31) == 0);
`else
      fl = 1'b0;
`endif
      apply($urandom_range(0, 63) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, fl, got_ir);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mxn_elastic_pipeline.md
Name: mxn_elastic_pipeline

Overview:
- M-bit wide, N-stage-deep pipeline with valid/ready handshakes at both ends.
- It is the consumer-facing counterpart to the free-running MxN flop pipeline: the downstream reader can apply backpressure, and the pipeline stalls and compresses bubbles without losing or duplicating data.
- Sits between a producer issuing one word per cycle and a reader that may stall.

Parameters:
- M, 3, data width in bits (M >= 1).
- N, 4, number of register stages (N >= 1).
- CW, 3, width of the occupancy output; must satisfy 2**CW > N (default covers N=4).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst_n  input  1  synchronous reset, active-low.
- in  input  M  write-side data word.
- in_valid  input  1  write side presents a word on in.
- in_ready  output  1  pipeline accepts the word this cycle.
- out  output  M  read-side data word (stage N register).
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  reader takes the word this cycle.
- occupancy  output  CW  number of valid stages, 0..N.
- flush  input  1  present only when PIPE_FLUSH_EN is defined.

Behaviour:
- State: data register d[k] (M bits) and valid bit v[k] for each stage k = 1..N. Stage 1 is the input end; stage N drives out.
- Reset: when rst_n = 0 at posedge clk, all v[k] = 0 and occupancy = 0. Therefore out_valid = 0 and in_ready = 1 in the cycle after reset. d[k] is don't-care, but the implementation clears it to 0 for determinism.
- Reset mid-operation drops all in-flight words; nothing is emitted afterwards.
- Combinational advance chain, evaluated from stage N down to stage 1:
  - adv[N] = v[N] & out_ready.
  - free[k] = ~v[k] | adv[k].
  - adv[k] = v[k] & free[k+1], for k < N.
- in_ready = free[1]. It is combinational from out_ready through the chain. No combinational path exists from in_valid to in_ready.
- Accept: a word is accepted when in_valid & in_ready. It is loaded into d[1] and v[1] is set.
- Stage move: when adv[k] holds, d[k+1] <= d[k] and v[k+1] <= 1.
- Stage hold:
  - A stage that neither loads nor shifts keeps its d and v.
  - A stage that shifts out without receiving a new word clears v.
- Latency: with no stall, a word accepted at edge t appears on out with out_valid = 1 after edge t+N-1, i.e. N cycles from acceptance. Throughput is 1 word per cycle.
- Bubble compression: an invalid stage always accepts from the stage above, even while out_ready = 0. A stalled pipeline therefore fills until all N stages are valid.
- Full: all v = 1 and out_ready = 0 → in_ready = 0; no state changes.
- Full with out_ready = 1: the whole chain advances; in_ready = 1, so simultaneous read and write sustains full throughput.
- Empty: out_valid = 0. out_ready is ignored. in_ready = 1.
- Ordering: output order equals acceptance order. No word is dropped or duplicated.
- occupancy: registered, equals the popcount of v. Its next value is occupancy + (accept) − (adv[N]). Simultaneous accept and emit leaves it unchanged. It never exceeds N.
- out and out_valid come straight from registers (d[N], v[N]), with no output logic.

Optional Feature:
- Macro PIPE_FLUSH_EN.
- Defined:
  - The flush input port exists.
  - flush = 1 at posedge clk clears all v[k] and occupancy to 0 on that edge; any in_valid word that cycle is discarded.
  - in_ready = 0 while flush = 1.
  - rst_n = 0 takes priority over flush.
- Undefined: no flush port and no flush logic; behaviour is exactly as above.

Test Plan (M=3, N=4):
- Reset then stream: in = 1..6 with in_valid = 1 and out_ready = 1 every cycle → out_valid first rises 4 cycles after the first accept; out = 1,2,3,4,5,6 on consecutive cycles; occupancy holds 4 once steady.
- Fill under stall: out_ready = 0, push 7,6,5,4,3 → first four accepted; in_ready = 0 on the fifth; occupancy = 4; out = 7 held stable.
- Simultaneous read/write when full: from the full state, out_ready = 1 and push 2 → out sequence 7,6,5,4,2; occupancy stays 4 while both sides are active.
- Bubble compression: push 1, idle 2 cycles, push 2, with out_ready = 0 → after 4 cycles the two words occupy stages 4 and 3; with out_ready = 1, 1 then 2 appear on back-to-back cycles.
- Reset mid-operation: with 3 words in flight, drive rst_n = 0 for one edge → out_valid = 0, occupancy = 0, in_ready = 1; no stale word ever appears on out.
- (PIPE_FLUSH_EN) with 4 words held, flush = 1 together with in_valid = 1 and in = 5 → after the edge occupancy = 0 and out_valid = 0; the value 5 never emerges.
